// File: rtl/crc_rx_checker_if.sv
// Serial CRC receive link interface.
// Carries the qualified serial bit stream into the checker and the
// checker's status/result signals back out.
//   data      serial bit, LSB first, valid when active = 1
//   active    bit qualifier, high for the whole frame
//   calc_crc  CRC recomputed over the payload (LFSR contents)
//   rx_crc    CRC bits received, first received bit in bit 0
//   done      one-cycle strobe, frame complete and crc_ok/err valid
//   crc_ok    last completed frame matched
//   err       last completed frame mismatched
//   abort     one-cycle strobe, active dropped mid-frame
// Modports: master = bit source / observer, slave = checker.
interface crc_rx_checker_if;
  logic       data;
  logic       active;
  logic [7:0] calc_crc;
  logic [7:0] rx_crc;
  logic       done;
  logic       crc_ok;
  logic       err;
  logic       abort;

  modport master (
    output data, active,
    input  calc_crc, rx_crc, done, crc_ok, err, abort
  );

  modport slave (
    input  data, active,
    output calc_crc, rx_crc, done, crc_ok, err, abort
  );
endinterface

// File: rtl/crc_rx_checker.sv
// Receive-side serial CRC-8 checker.
// Accepts a serial frame of DATA_BITS payload bits followed by 8 CRC bits,
// recomputes the CRC over the payload with the generator's LFSR and
// compares it with the received CRC, reporting the result with a one-cycle
// done strobe. A frame cut short by active falling reports abort instead.
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  crc_rx_checker_if.slave (data/active in, results out)
module crc_rx_checker #(
  parameter int         DATA_BITS = 8,
  parameter logic [7:0] SEED      = 8'hD8,
  parameter logic [7:0] POLY      = 8'h44
) (
  input  logic             clk,
  input  logic             rst,
  crc_rx_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC
  } state_t;

  localparam logic [7:0] LAST_DATA = 8'(DATA_BITS - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] lfsr, lfsr_n;
  logic [7:0] rx_crc, rx_crc_n;
  logic       done, done_n;
  logic       abort, abort_n;
  logic       crc_ok, crc_ok_n;
  logic       err, err_n;

  // One LFSR step: feedback enters at the top and is XORed into every
  // tap position selected by POLY[6:0] as the register shifts down.
  function automatic logic [7:0] lfsr_step(input logic [7:0] r, input logic d);
    logic       fb;
    logic [7:0] nxt;
    fb     = d ^ r[0];
    nxt[7] = fb;
    for (int i = 0; i < 7; i++) begin
      nxt[i] = r[i+1] ^ (POLY[i] & fb);
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      lfsr   <= SEED;
      rx_crc <= 8'd0;
      done   <= 1'b0;
      abort  <= 1'b0;
      crc_ok <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      lfsr   <= lfsr_n;
      rx_crc <= rx_crc_n;
      done   <= done_n;
      abort  <= abort_n;
      crc_ok <= crc_ok_n;
      err    <= err_n;
    end
  end

  // Next-state logic. done/abort default low so they are single-cycle
  // pulses; crc_ok/err hold until a new frame starts or an abort occurs.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lfsr_n   = lfsr;
    rx_crc_n = rx_crc;
    done_n   = 1'b0;
    abort_n  = 1'b0;
    crc_ok_n = crc_ok;
    err_n    = err;

    unique case (state)
      ST_IDLE: begin
        // The first active bit is payload bit 0; the LFSR restarts from
        // SEED here, which also covers a frame starting in the done cycle.
        if (bus.active) begin
          lfsr_n   = lfsr_step(SEED, bus.data);
          crc_ok_n = 1'b0;
          err_n    = 1'b0;
          if (DATA_BITS == 1) begin
            cnt_n   = 8'd0;
            state_n = ST_CRC;
          end else begin
            cnt_n   = 8'd1;
            state_n = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (bus.active) begin
          lfsr_n = lfsr_step(lfsr, bus.data);
          if (cnt == LAST_DATA) begin
            cnt_n   = 8'd0;
            state_n = ST_CRC;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n  = ST_IDLE;
          abort_n  = 1'b1;
          crc_ok_n = 1'b0;
          err_n    = 1'b0;
          lfsr_n   = SEED;
          cnt_n    = 8'd0;
        end
      end

      ST_CRC: begin
        if (bus.active) begin
          rx_crc_n = {bus.data, rx_crc[7:1]};
          if (cnt == 8'd7) begin
            // Compare against the shifted value so the final bit counts.
            state_n  = ST_IDLE;
            cnt_n    = 8'd0;
            done_n   = 1'b1;
            crc_ok_n = (rx_crc_n == lfsr);
            err_n    = (rx_crc_n != lfsr);
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n  = ST_IDLE;
          abort_n  = 1'b1;
          crc_ok_n = 1'b0;
          err_n    = 1'b0;
          lfsr_n   = SEED;
          cnt_n    = 8'd0;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.calc_crc = lfsr;
  assign bus.rx_crc   = rx_crc;
  assign bus.done     = done;
  assign bus.crc_ok   = crc_ok;
  assign bus.err      = err;
  assign bus.abort    = abort;

endmodule

// File: tb/tb_crc_rx_checker.sv
// Testbench for crc_rx_checker (DATA_BITS = 8, default SEED/POLY).
// Expected frame results are queued when a frame is driven; every observed
// done strobe is queued by the driver, and each scenario task pops and
// compares the two. Inputs change 1 ns after the rising edge and outputs
// are sampled 1 ns after the rising edge.
module tb_crc_rx_checker;

  localparam logic [7:0] SEED = 8'hD8;
  localparam logic [7:0] POLY = 8'h44;

  typedef struct {
    int         cyc;
    logic       ok;
    logic [7:0] calc;
    logic [7:0] rx;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       ok;
    logic       err;
    logic [7:0] calc;
    logic [7:0] rx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   abort_seen = 0;
  int   overlap_seen = 0;

  exp_t exp_q[$];
  obs_t obs_q[$];

  crc_rx_checker_if bus();

  crc_rx_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC written as a whole-register shift with a feedback mask.
  function automatic logic [7:0] crc_model(input logic [7:0] payload);
    logic [7:0] r;
    logic       fb;
    r = SEED;
    for (int i = 0; i < 8; i++) begin
      fb = payload[i] ^ r[0];
      r  = (r >> 1) ^ (fb ? (8'h80 | (POLY & 8'h7F)) : 8'h00);
    end
    return r;
  endfunction

  // Drive one bit for one clock and record what the checker reports.
  task automatic drive_cycle(input logic d, input logic a);
    bus.data   = d;
    bus.active = a;
    @(posedge clk);
    #1;
    if (bus.done) begin
      obs_t o;
      o.cyc  = cyc;
      o.ok   = bus.crc_ok;
      o.err  = bus.err;
      o.calc = bus.calc_crc;
      o.rx   = bus.rx_crc;
      obs_q.push_back(o);
    end
    if (bus.abort) abort_seen++;
    if (bus.abort && bus.done) overlap_seen++;
  endtask

  // Queue the expected result, then drive payload and CRC LSB first.
  task automatic send_frame(input logic [7:0] payload, input logic [7:0] crc);
    exp_t       e;
    logic [15:0] bits;
    e.calc = crc_model(payload);
    e.rx   = crc;
    e.ok   = (crc == e.calc);
    e.cyc  = cyc + 16;
    exp_q.push_back(e);
    bits = {crc, payload};
    for (int i = 0; i < 16; i++) drive_cycle(bits[i], 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (bus.calc_crc !== SEED) begin
      n_fail++; $display("[TB] FAIL reset_calc_crc got %h want %h", bus.calc_crc, SEED);
    end
    n_checks++;
    if (bus.rx_crc !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_rx_crc got %h want 00", bus.rx_crc);
    end
    n_checks++;
    if ({bus.done, bus.crc_ok, bus.err, bus.abort} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got done/ok/err/abort %b want 0000",
               {bus.done, bus.crc_ok, bus.err, bus.abort});
    end
    n_checks++;
    if (crc_model(8'h00) !== 8'h14) begin
      n_fail++; $display("[TB] FAIL model_anchor got %h want 14", crc_model(8'h00));
    end
  endtask

  task automatic test_good_frame;
    exp_t e;
    obs_t o;
    send_frame(8'h00, 8'h14);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL good_done got no done want done at cycle %0d", e.cyc);
    end else begin
      o = obs_q.pop_front();
      if (o.cyc !== e.cyc || o.ok !== 1'b1 || o.err !== 1'b0 ||
          o.calc !== 8'h14 || o.rx !== 8'h14) begin
        n_fail++;
        $display("[TB] FAIL good_frame got cyc %0d ok %b err %b calc %h rx %h want cyc %0d ok 1 err 0 calc 14 rx 14",
                 o.cyc, o.ok, o.err, o.calc, o.rx, e.cyc);
      end
    end
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (bus.done !== 1'b0 || bus.crc_ok !== 1'b1 || bus.calc_crc !== 8'h14) begin
      n_fail++;
      $display("[TB] FAIL good_after got done %b ok %b calc %h want done 0 ok 1 calc 14",
               bus.done, bus.crc_ok, bus.calc_crc);
    end
  endtask

  task automatic test_bad_crc;
    exp_t e;
    obs_t o;
    send_frame(8'h00, 8'h15);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL bad_done got no done want done at cycle %0d", e.cyc);
    end else begin
      o = obs_q.pop_front();
      if (o.cyc !== e.cyc || o.ok !== 1'b0 || o.err !== 1'b1 ||
          o.calc !== 8'h14 || o.rx !== 8'h15) begin
        n_fail++;
        $display("[TB] FAIL bad_frame got cyc %0d ok %b err %b calc %h rx %h want cyc %0d ok 0 err 1 calc 14 rx 15",
                 o.cyc, o.ok, o.err, o.calc, o.rx, e.cyc);
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (bus.crc_ok !== 1'b0 || bus.err !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bad_hold got ok %b err %b done %b want ok 0 err 1 done 0",
               bus.crc_ok, bus.err, bus.done);
    end
  endtask

  task automatic test_abort;
    int aborts_before;
    aborts_before = abort_seen;
    drive_cycle(1'b1, 1'b1);
    n_checks++;
    if (bus.err !== 1'b0 || bus.crc_ok !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flags_clear got ok %b err %b want ok 0 err 0", bus.crc_ok, bus.err);
    end
    for (int i = 0; i < 4; i++) drive_cycle(i[0], 1'b1);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (bus.abort !== 1'b1 || bus.done !== 1'b0 || bus.calc_crc !== SEED) begin
      n_fail++;
      $display("[TB] FAIL abort_pulse got abort %b done %b calc %h want abort 1 done 0 calc %h",
               bus.abort, bus.done, bus.calc_crc, SEED);
    end
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (abort_seen - aborts_before !== 1 || obs_q.size() !== 0 ||
        bus.crc_ok !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_after got aborts %0d dones %0d ok %b err %b want aborts 1 dones 0 ok 0 err 0",
               abort_seen - aborts_before, obs_q.size(), bus.crc_ok, bus.err);
    end
    send_frame(8'h00, 8'h14);
    drive_cycle(1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL post_abort_done got no done want ok %b", e.ok);
      end else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.calc !== e.calc || o.rx !== e.rx || o.cyc !== e.cyc) begin
          n_fail++;
          $display("[TB] FAIL post_abort_frame got ok %b calc %h rx %h cyc %0d want ok %b calc %h rx %h cyc %0d",
                   o.ok, o.calc, o.rx, o.cyc, e.ok, e.calc, e.rx, e.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_t o1, o2;
    send_frame(8'h00, 8'h14);
    send_frame(8'h00, 8'h14);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("[TB] FAIL b2b_count got %0d dones want 2", obs_q.size());
      obs_q.delete();
    end else begin
      o1 = obs_q.pop_front();
      o2 = obs_q.pop_front();
      if (o2.cyc - o1.cyc !== 16 || o1.ok !== 1'b1 || o2.ok !== 1'b1 ||
          o1.cyc !== exp_q[0].cyc) begin
        n_fail++;
        $display("[TB] FAIL b2b_frames got gap %0d ok %b/%b cyc %0d want gap 16 ok 1/1 cyc %0d",
                 o2.cyc - o1.cyc, o1.ok, o2.ok, o1.cyc, exp_q[0].cyc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] bits;
    int dones_before;
    dones_before = obs_q.size();
    bits = {8'h14, 8'h00};
    for (int i = 0; i < 10; i++) drive_cycle(bits[i], 1'b1);
    rst = 1'b1;
    drive_cycle(1'b1, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (bus.calc_crc !== SEED || bus.rx_crc !== 8'h00 ||
        {bus.done, bus.crc_ok, bus.err, bus.abort} !== 4'b0000 ||
        obs_q.size() !== dones_before) begin
      n_fail++;
      $display("[TB] FAIL mid_reset got calc %h rx %h flags %b dones %0d want calc %h rx 00 flags 0000 dones %0d",
               bus.calc_crc, bus.rx_crc, {bus.done, bus.crc_ok, bus.err, bus.abort},
               obs_q.size(), SEED, dones_before);
    end
    drive_cycle(1'b0, 1'b0);
    send_frame(8'h00, 8'h14);
    drive_cycle(1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("[TB] FAIL post_reset_count got %0d dones want 1", obs_q.size());
      obs_q.delete();
    end else begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.ok !== 1'b1 || o.cyc !== e.cyc || o.rx !== 8'h14) begin
        n_fail++;
        $display("[TB] FAIL post_reset_frame got ok %b cyc %0d rx %h want ok 1 cyc %0d rx 14",
                 o.ok, o.cyc, o.rx, e.cyc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_idle;
    rst = 1'b1;
    drive_cycle(1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(i[0], 1'b0);
      n_checks++;
      if (bus.calc_crc !== SEED || bus.rx_crc !== 8'h00 ||
          {bus.done, bus.crc_ok, bus.err, bus.abort} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL idle_%0d got calc %h rx %h flags %b want calc %h rx 00 flags 0000",
                 i, bus.calc_crc, bus.rx_crc, {bus.done, bus.crc_ok, bus.err, bus.abort}, SEED);
      end
    end
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 8; f++) begin
      logic [7:0] p, c;
      p = 8'($urandom_range(0, 255));
      c = crc_model(p);
      if (f[0]) c = c ^ (8'h01 << $urandom_range(0, 7));
      send_frame(p, c);
      for (int g = 0; g < (f % 3); g++) drive_cycle(1'b0, 1'b0);
    end
    drive_cycle(1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL rand_done got no done want ok %b at cycle %0d", e.ok, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== !e.ok || o.calc !== e.calc ||
            o.rx !== e.rx || o.cyc !== e.cyc) begin
          n_fail++;
          $display("[TB] FAIL rand_frame got ok %b err %b calc %h rx %h cyc %0d want ok %b calc %h rx %h cyc %0d",
                   o.ok, o.err, o.calc, o.rx, o.cyc, e.ok, e.calc, e.rx, e.cyc);
        end
      end
    end
    n_checks++;
    if (overlap_seen !== 0 || obs_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL done_abort_overlap got overlaps %0d extra dones %0d want 0 0",
               overlap_seen, obs_q.size());
    end
  endtask

  initial begin
    bus.data   = 1'b0;
    bus.active = 1'b0;
    #1;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_idle();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
